// File: rtl/btb_pkg.sv
// Shared types for the execute-side BTB resolver: the prediction metadata
// carried down the pipe, the fall-through PC step, and the miss classifier.
package btb_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_take;
    logic [31:0] pred_pc;
  } pred_meta_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Why a resolved instruction disagreed with its prediction (HIT = agreed).
  typedef enum logic [1:0] {
    HIT      = 2'd0,
    DIR_MISS = 2'd1,
    TGT_MISS = 2'd2,
    ALIAS    = 2'd3
  } miss_cause_t;

  // Classify the outcome of one resolved instruction against its prediction.
  function automatic miss_cause_t classify(
    input logic        is_br,
    input logic        taken,
    input logic [31:0] target,
    input logic        pred_take,
    input logic [31:0] pred_pc
  );
    miss_cause_t c;
    c = HIT;
    if (is_br) begin
      if (taken != pred_take)             c = DIR_MISS;
      else if (taken && target != pred_pc) c = TGT_MISS;
    end else if (pred_take) begin
      c = ALIAS;
    end
    return c;
  endfunction

endpackage

// File: rtl/bp_meta_reg.sv
// One stage of the prediction metadata pipe. Kill clears only the valid bit
// and overrides load; otherwise the register loads or holds.
module bp_meta_reg
  import btb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kill,
  input  logic       load,
  input  pred_meta_t d,
  output pred_meta_t q
);

  // Metadata register: kill beats load, load beats hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (kill) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/btb_resolver.sv
// Execute-stage BTB resolver. Carries each fetched instruction's prediction
// through IF->ID->EX, compares it with the outcome resolved in EX in the same
// cycle, and drives the front-end redirect, the BTB write port and two
// saturating performance counters.
//
// Handshake: there is no back-pressure. A result exists in any cycle where
// the E entry is valid and no flush is present; redirect and btb_wr_en are
// single-cycle strobes the consumer must take in that cycle. All resolve
// outputs read zero in every other cycle.
module btb_resolver
  import btb_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             if_pred_take,
  input  logic [31:0]      if_pred_pc,
  input  logic             stall_d,
  input  logic             bubble_e,
  input  logic             flush_i,
  input  logic             ex_is_br,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             btb_wr_en,
  output logic [31:0]      btb_wr_pc,
  output logic [31:0]      btb_wr_target,
  output logic             btb_taken,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pred_meta_t  d_in, d_q, e_in, e_q;
  miss_cause_t cause;
  logic        active;
  logic        miss;
  logic        kill;

  assign d_in = '{valid: if_valid, pc: if_pc, pred_take: if_pred_take, pred_pc: if_pred_pc};

  // A stalled D leaves nothing to advance, so E takes a bubble as well.
  assign e_in = (bubble_e || stall_d) ? '0 : d_q;

  assign active = e_q.valid && !flush_i;
  assign miss   = active && (cause != HIT);
  assign kill   = miss || flush_i;

  bp_meta_reg u_meta_d (
    .clk   (clk),
    .rst_n (rst_n),
    .kill  (kill),
    .load  (!stall_d),
    .d     (d_in),
    .q     (d_q)
  );

  bp_meta_reg u_meta_e (
    .clk   (clk),
    .rst_n (rst_n),
    .kill  (kill),
    .load  (1'b1),
    .d     (e_in),
    .q     (e_q)
  );

  // Classify the EX instruction against the prediction it carried.
  always_comb begin
    cause = classify(ex_is_br, ex_taken, ex_target, e_q.pred_take, e_q.pred_pc);
  end

  // Resolve outputs; everything reads zero unless a valid, unflushed entry is in EX.
  always_comb begin
    redirect      = 1'b0;
    redirect_pc   = 32'd0;
    btb_wr_en     = 1'b0;
    btb_wr_pc     = 32'd0;
    btb_wr_target = 32'd0;
    btb_taken     = 1'b0;
    if (active) begin
      redirect      = miss;
      redirect_pc   = (ex_is_br && ex_taken) ? ex_target : e_q.pc + PC_STEP;
      btb_wr_en     = miss;
      btb_wr_pc     = e_q.pc;
      btb_wr_target = ex_target;
      btb_taken     = ex_is_br && ex_taken;
    end
  end

  // Saturating counters of resolved branches and mispredictions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (active) begin
      if (ex_is_br && br_cnt != '1) br_cnt   <= br_cnt + CNT_ONE;
      if (miss && miss_cnt != '1)   miss_cnt <= miss_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_btb_resolver.sv
// Bench for btb_resolver. Counters are narrowed so saturation is reachable.
module tb_btb_resolver;
  import btb_pkg::*;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             redirect;
    logic [31:0]      rpc;
    logic             wr_en;
    logic [31:0]      wr_pc;
    logic [31:0]      wr_tgt;
    logic             taken;
    logic [CNT_W-1:0] br;
    logic [CNT_W-1:0] mc;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             if_valid = 0, if_pred_take = 0, stall_d = 0, bubble_e = 0, flush_i = 0;
  logic             ex_is_br = 0, ex_taken = 0;
  logic [31:0]      if_pc = 0, if_pred_pc = 0, ex_target = 0;
  logic             redirect, btb_wr_en, btb_taken;
  logic [31:0]      redirect_pc, btb_wr_pc, btb_wr_target;
  logic [CNT_W-1:0] br_cnt, miss_cnt;

  btb_resolver #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc), .if_pred_take(if_pred_take), .if_pred_pc(if_pred_pc),
    .stall_d(stall_d), .bubble_e(bubble_e), .flush_i(flush_i),
    .ex_is_br(ex_is_br), .ex_taken(ex_taken), .ex_target(ex_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .btb_wr_en(btb_wr_en), .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target), .btb_taken(btb_taken),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Two in-flight slots (ID, EX) and plain integer counters.
  pred_meta_t m_d, m_e;
  int         m_br, m_mc;
  logic       m_rst = 1'b0;   // value of rst_n to drive on the next cycle

  logic [OBS_W-1:0] exp_q[$];

  // Sampled DUT values of the most recent cycle, for directed checks.
  obs_t s;

  function automatic obs_t model_out(input logic fl, br, tk, input logic [31:0] tgt, output logic miss);
    obs_t o;
    logic act;
    o = '0;
    act = m_rst && m_e.valid && !fl;
    if (br) miss = (tk != m_e.pred_take) || (tk && tgt != m_e.pred_pc);
    else    miss = m_e.pred_take;
    miss = miss && act;
    if (act) begin
      o.redirect = miss;
      o.rpc      = (br && tk) ? tgt : m_e.pc + 32'd4;
      o.wr_en    = miss;
      o.wr_pc    = m_e.pc;
      o.wr_tgt   = tgt;
      o.taken    = br && tk;
    end
    o.br = CNT_W'(m_br);
    o.mc = CNT_W'(m_mc);
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input logic iv, input logic [31:0] ipc, input logic ipt, input logic [31:0] ippc,
                     input logic st, input logic bub, input logic fl,
                     input logic br, input logic tk, input logic [31:0] tgt);
    obs_t o;
    logic miss, act;
    pred_meta_t nd;
    @(negedge clk);
    rst_n = m_rst;
    if (!m_rst) begin
      m_d = '0; m_e = '0; m_br = 0; m_mc = 0;
    end
    if_valid = iv; if_pc = ipc; if_pred_take = ipt; if_pred_pc = ippc;
    stall_d = st; bubble_e = bub; flush_i = fl;
    ex_is_br = br; ex_taken = tk; ex_target = tgt;
    #1;
    o = model_out(fl, br, tk, tgt, miss);
    exp_q.push_back(o);
    #2;
    s = '{redirect, redirect_pc, btb_wr_en, btb_wr_pc, btb_wr_target, btb_taken, br_cnt, miss_cnt};
    @(posedge clk);
    #1;
    if (m_rst) begin
      act = m_e.valid && !fl;
      if (act && br && m_br < CMAX) m_br++;
      if (miss && m_mc < CMAX) m_mc++;
      if (miss || fl) begin
        m_d.valid = 1'b0;
        m_e.valid = 1'b0;
      end else begin
        nd = '{valid: iv, pc: ipc, pred_take: ipt, pred_pc: ippc};
        m_e = (st || bub) ? '0 : m_d;
        if (!st) m_d = nd;
      end
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Fetch one instruction, let it reach EX, then resolve it with the given outcome.
  task automatic run_one(input logic [31:0] pc, input logic pt, input logic [31:0] ppc,
                         input logic st, input logic fl,
                         input logic br, input logic tk, input logic [31:0] tgt);
    cyc(1, pc, pt, ppc, 0, 0, 0, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 0, st, 0, fl, br, tk, tgt);
  endtask

  task automatic rnd_cycle();
    logic tk, br;
    logic [31:0] tgt;
    br  = $urandom_range(0, 1);
    tk  = ($urandom_range(0, 9) < 7) ? m_e.pred_take : ~m_e.pred_take;
    tgt = ($urandom_range(0, 1) == 1) ? m_e.pred_pc : {$urandom_range(0, 255), 2'b00};
    cyc($urandom_range(0, 3) != 0, {$urandom(), 2'b00} & 32'hFFFF_FFFC, $urandom_range(0, 1),
        {$urandom_range(0, 255), 2'b00},
        $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
        br, tk, tgt);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    obs_t e, a;
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{redirect, redirect_pc, btb_wr_en, btb_wr_pc, btb_wr_target, btb_taken, br_cnt, miss_cnt};
      chk("resolve", 128'(a[OBS_W-1:2*CNT_W]), 128'(e[OBS_W-1:2*CNT_W]));
      chk("br_cnt", 128'(a.br), 128'(e.br));
      chk("miss_cnt", 128'(a.mc), 128'(e.mc));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    m_d = '0; m_e = '0; m_br = 0; m_mc = 0;
    m_rst = 1'b0;
    idle(); idle();
    chk("reset_outputs", 128'(s), 128'(0));
    m_rst = 1'b1;
    idle();
    chk("first_after_release", 128'(s), 128'(0));

    // cold taken branch
    run_one(32'h100, 0, 32'h0, 0, 0, 1, 1, 32'h80);
    chk("cold_redirect", 128'({s.redirect, s.wr_en, s.taken}), 128'(3'b111));
    chk("cold_rpc", 128'(s.rpc), 128'(32'h80));
    chk("cold_tgt", 128'(s.wr_tgt), 128'(32'h80));
    idle();
    chk("cold_miss_cnt", 128'(s.mc), 128'(1));

    // correctly predicted taken branch
    run_one(32'h100, 1, 32'h80, 0, 0, 1, 1, 32'h80);
    chk("hit_redirect", 128'(s.redirect), 128'(0));
    idle();
    chk("hit_counts", 128'({s.br, s.mc}), 128'({4'd2, 4'd1}));

    // not-taken mispredict at the top of the address space
    run_one(32'hFFFF_FFFC, 1, 32'h40, 0, 0, 1, 0, 32'h40);
    chk("wrap_rpc", 128'(s.rpc), 128'(32'h0));
    chk("wrap_wr", 128'({s.wr_pc, s.taken, s.wr_en}), 128'({32'hFFFF_FFFC, 1'b0, 1'b1}));

    // younger instruction in D is killed by the redirect, with and without stall
    for (int v = 0; v < 2; v++) begin
      cyc(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 32'h300, 1, 32'h999, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, v[0], 0, 0, 1, 1, 32'h500);
      chk("kill_first_redirect", 128'(s.redirect), 128'(1));
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h700);
      chk("kill_no_second", 128'({s.redirect, s.wr_en}), 128'(0));
      idle();
    end

    // flush on a mispredicting E
    run_one(32'h400, 0, 32'h0, 0, 1, 1, 1, 32'h800);
    chk("flush_no_redirect", 128'({s.redirect, s.wr_en}), 128'(0));
    idle();
    chk("flush_no_count", 128'({s.br, s.mc}), 128'({4'd5, 4'd4}));

    // saturation
    for (int i = 0; i < CMAX + 3; i++) run_one(32'h600, 0, 32'h0, 0, 0, 1, 1, 32'h20);
    idle();
    chk("sat_counts", 128'({s.br, s.mc}), 128'({4'hF, 4'hF}));

    // randomized traffic
    for (int i = 0; i < 1500; i++) rnd_cycle();

    // reset mid-stream, then quiet
    m_rst = 1'b0;
    idle();
    chk("midreset_outputs", 128'(s), 128'(0));
    m_rst = 1'b1;
    idle();
    idle();
    chk("post_reset_no_wr", 128'(s.wr_en), 128'(0));
    idle();
    chk("post_reset_no_wr2", 128'(s.wr_en), 128'(0));

    for (int i = 0; i < 500; i++) rnd_cycle();
    idle();
    @(negedge clk);
    #4;
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
